// File: rtl/a2_audio_pkg.sv
// rtl/a2_audio_pkg.sv - shared audio-path types and constants
package a2_audio_pkg;

  // Default PCM width delivered per channel
  localparam int AUDIO_DW_DEF = 16;

  // lrck level that marks the right-channel slot
  localparam logic LRCK_RIGHT = 1'b1;

  // Receiver word-tracking states
  typedef enum logic [1:0] {
    SEEK,
    SHIFT,
    HOLD
  } i2s_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - 1-bit multi-stage synchroniser for async inputs
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the async input through the flop chain; oldest stage is the output
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/i2s_audio_rx.sv
// rtl/i2s_audio_rx.sv - I2S line-in receiver producing stereo PCM words
module i2s_audio_rx
  import a2_audio_pkg::*;
#(
  parameter int AUDIO_DW       = AUDIO_DW_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bck,
  input  logic                i2s_lrck,
  input  logic                i2s_data,
  output logic [AUDIO_DW-1:0] left,
  output logic [AUDIO_DW-1:0] right,
  output logic                sample_valid,
  output logic                locked
);

  localparam int CW = $clog2(AUDIO_DW + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic bck_s, lrck_s, data_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bck (
    .clk(clk), .reset(reset), .d_i(i2s_bck), .q_o(bck_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk(clk), .reset(reset), .d_i(i2s_lrck), .q_o(lrck_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .d_i(i2s_data), .q_o(data_s)
  );

  i2s_rx_state_t       state_q, state_d;
  logic                bck_prev_q;
  logic                lrck_lat_q;
  logic [AUDIO_DW-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AUDIO_DW-1:0] stage_q, stage_d;
  logic                stage_vld_q, stage_vld_d;
  logic [AUDIO_DW-1:0] left_q, left_d;
  logic [AUDIO_DW-1:0] right_q, right_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic [WW-1:0]       wd_q, wd_d;

  logic                bck_rise;
  logic                lrck_edge;
  logic                wd_hit;
  logic                room;
  logic [AUDIO_DW-1:0] shift_in;
  logic [CW-1:0]       fill;
  logic [AUDIO_DW-1:0] word_raw;
  logic [AUDIO_DW-1:0] word;

  // Edge detection and the left-aligned word a commit would produce
  always_comb begin
    bck_rise  = bck_s & ~bck_prev_q;
    lrck_edge = bck_rise & (lrck_s != lrck_lat_q);
    wd_hit    = ~bck_rise & (wd_q == WW'(TIMEOUT_CYCLES - 1));
    room      = (cnt_q < CW'(AUDIO_DW));
    shift_in  = {shift_q[AUDIO_DW-2:0], data_s};
    fill      = room ? (cnt_q + CW'(1)) : cnt_q;
    word_raw  = room ? shift_in : shift_q;
    // Short slots land in the LSBs; move them to the top and pad with zeros
    word      = word_raw << (CW'(AUDIO_DW) - fill);
  end

  // Slot FSM, commit/staging logic and BCK watchdog
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    stage_vld_d = stage_vld_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    wd_d        = wd_q;

    if (bck_rise) begin
      wd_d = '0;
    end else if (wd_q != WW'(TIMEOUT_CYCLES)) begin
      wd_d = wd_q + WW'(1);
    end

    case (state_q)
      SEEK: begin
        if (lrck_edge) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT, HOLD: begin
        if (lrck_edge) begin
          // lrck_lat_q still names the slot that just finished
          if (lrck_lat_q != LRCK_RIGHT) begin
            stage_d     = word;
            stage_vld_d = 1'b1;
          end else if (stage_vld_q) begin
            left_d      = stage_q;
            right_d     = word;
            valid_d     = 1'b1;
            locked_d    = 1'b1;
            stage_vld_d = 1'b0;
          end
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (bck_rise && (state_q == SHIFT)) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(AUDIO_DW)) begin
            state_d = HOLD;
          end
        end
      end
      default: state_d = SEEK;
    endcase

    // Lost bit clock: drop lock and resynchronise, keep last outputs
    if (wd_hit) begin
      locked_d    = 1'b0;
      state_d     = SEEK;
      stage_vld_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEEK;
      bck_prev_q  <= 1'b0;
      lrck_lat_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      bck_prev_q  <= bck_s;
      if (bck_rise) begin
        lrck_lat_q <= lrck_s;
      end
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      wd_q        <= wd_d;
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// tb/tb_i2s_audio_rx.sv - self-checking bench for i2s_audio_rx
module tb_i2s_audio_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_data;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample_valid;
  logic        locked;

  always #5 clk = ~clk;

  i2s_audio_rx #(
    .AUDIO_DW(16),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i2s_bck(i2s_bck),
    .i2s_lrck(i2s_lrck),
    .i2s_data(i2s_data),
    .left(left),
    .right(right),
    .sample_valid(sample_valid),
    .locked(locked)
  );

  int          errors = 0;
  int          checks = 0;
  int          strobes = 0;
  int          half = 4;
  logic        prev_bit = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic [15:0] last_l, last_r;

  // Scoreboard consumer: every strobe must match the oldest expected pair
  always @(negedge clk) begin
    if (sample_valid) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got left=%h right=%h required no strobe", left, right);
      end else begin
        mon_e = exp_q.pop_front();
        if ({left, right} !== mon_e) begin
          errors++;
          $display("FAIL sample_pair got left=%h right=%h required left=%h right=%h",
                   left, right, mon_e[31:16], mon_e[15:0]);
        end
      end
    end
  end

  function automatic logic [15:0] expw(input logic [31:0] w, input int n);
    logic [31:0] t;
    if (n >= 16) t = w >> (n - 16);
    else         t = w << (16 - n);
    return t[15:0];
  endfunction

  // One BCK period; data carries the previous bit (I2S one-bit delay)
  task automatic send_period(input logic lr, input logic nb);
    i2s_bck  = 1'b0;
    i2s_lrck = lr;
    i2s_data = prev_bit;
    prev_bit = nb;
    repeat (half) @(negedge clk);
    i2s_bck = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] w, input int n,
                           input int from, input int upto);
    for (int j = from; j < upto; j++) send_period(lr, w[n-1-j]);
  endtask

  task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int n,
                            input bit expect_out);
    if (expect_out) begin
      exp_q.push_back({expw(lw, n), expw(rw, n)});
      last_l = expw(lw, n);
      last_r = expw(rw, n);
    end
    send_slot(1'b0, lw, n, 0, n);
    send_slot(1'b1, rw, n, 0, n);
  endtask

  // Deliver the last right LSB, then confirm every expected pair arrived
  task automatic flush(input string name);
    send_period(1'b0, 1'b0);
    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_strobes got %0d pending required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i2s_bck = 1'b1; i2s_lrck = 1'b0; i2s_data = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_left", 32'(left), 32'h0);
    chk("reset_right", 32'(right), 32'h0);
    chk("reset_valid", 32'(sample_valid), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_slot(input string name, input int n, input logic [31:0] lw,
                           input logic [31:0] rw);
    int s0;
    do_reset();
    s0 = strobes;
    send_frame(lw, rw, n, 1'b0);
    chk({name, "_unlocked"}, 32'(locked), 32'h0);
    for (int i = 0; i < 3; i++) send_frame(lw, rw, n, 1'b1);
    flush(name);
    chk({name, "_strobes"}, 32'(strobes - s0), 32'd3);
    chk({name, "_locked"}, 32'(locked), 32'h1);
    chk({name, "_pair"}, {left, right}, {expw(lw, n), expw(rw, n)});
  endtask

  task automatic test_midstart_timeout();
    int s0;
    logic [15:0] a, b;
    do_reset();
    s0 = strobes;
    send_slot(1'b1, 32'($urandom), 16, 9, 16);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      send_frame(32'(a), 32'(b), 16, 1'b1);
    end
    flush("midstart");
    chk("midstart_strobes", 32'(strobes - s0), 32'd3);
    chk("midstart_locked", 32'(locked), 32'h1);
    s0 = strobes;
    i2s_bck = 1'b0;
    repeat (1100) @(negedge clk);
    chk("timeout_locked", 32'(locked), 32'h0);
    chk("timeout_hold", {left, right}, {last_l, last_r});
    chk("timeout_strobes", 32'(strobes - s0), 32'd0);
    send_frame(32'h0000_1111, 32'h0000_2222, 16, 1'b0);
    chk("resume_unlocked", 32'(locked), 32'h0);
    send_frame(32'h0000_3333, 32'h0000_4444, 16, 1'b1);
    flush("resume");
    chk("resume_locked", 32'(locked), 32'h1);
    chk("resume_strobes", 32'(strobes - s0), 32'd1);
  endtask

  task automatic test_reset_midslot();
    int s0;
    do_reset();
    send_frame(32'h0000_0F0F, 32'h0000_F0F0, 16, 1'b0);
    send_frame(32'h0000_1357, 32'h0000_2468, 16, 1'b1);
    send_slot(1'b0, 32'h0000_9999, 16, 0, 8);
    chk("midreset_pre_queue", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_left", 32'(left), 32'h0);
    chk("midreset_right", 32'(right), 32'h0);
    chk("midreset_locked", 32'(locked), 32'h0);
    chk("midreset_valid", 32'(sample_valid), 32'h0);
    s0 = strobes;
    send_slot(1'b0, 32'h0000_9999, 16, 8, 16);
    send_slot(1'b1, 32'h0000_7777, 16, 0, 16);
    chk("midreset_no_partial", 32'(strobes - s0), 32'd0);
    send_frame(32'h0000_CAFE, 32'h0000_BEEF, 16, 1'b1);
    flush("midreset");
    chk("midreset_strobes", 32'(strobes - s0), 32'd1);
    chk("midreset_locked_after", 32'(locked), 32'h1);
  endtask

  task automatic test_back_to_back();
    int s0;
    half = 2;
    do_reset();
    s0 = strobes;
    for (int i = 0; i < 200; i++) begin
      send_frame(32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)), 16, i > 0);
    end
    flush("ratio4x");
    chk("ratio4x_strobes", 32'(strobes - s0), 32'd199);
    half = 4;
  endtask

  initial begin
    test_reset();
    test_slot("slot16", 16, 32'h0000_1234, 32'h0000_ABCD);
    test_slot("slot32", 32, 32'h8001_FFFF, 32'h7FFE_0000);
    test_slot("slot8", 8, 32'h0000_00A5, 32'h0000_005A);
    test_midstart_timeout();
    test_reset_midslot();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
